btn_debounce: RTL and testbench

Debounces one asynchronous mechanical push-button input and produces a clean level plus single-cycle edge pulses. It sits directly upstream of the D flip-flop stage: `btn_level` drives the flip-flop's D input, and `btn_rise` is the qualified strobe used for its synchronous clear. It is sequential throughout: a two-stage synchronizer, a stability counter, a four-state FSM, edge pulses and a saturating press counter.

---
 rtl/btn_debounce_pkg.sv | 17 +
 rtl/btn_debounce_sync2.sv | 27 ++
 rtl/btn_debounce.sv | 100 ++++++++++
 tb/tb_btn_debounce.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the mapping from state to debounced level.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HIGH    = 2'b10,
    ST_WAIT_LO = 2'b11
  } state_t;

  // The accepted level is high while settled high or while qualifying a release.
  function automatic logic level_of(input state_t s);
    return (s == ST_HIGH) || (s == ST_WAIT_LO);
  endfunction

endpackage

// File: rtl/btn_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterised reset value so it can be reused for idle-high inputs.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk1,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, stability-qualified four-state FSM,
// registered level with single-cycle rise/fall strobes and a saturating
// press counter.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int PRESS_W       = 8
) (
  input  logic               clk1,
  input  logic               reset_n,
  input  logic               btn_raw,
  output logic               btn_level,
  output logic               btn_rise,
  output logic               btn_fall,
  output logic [PRESS_W-1:0] press_count
);

  localparam logic [CNT_W-1:0]   TERMINAL  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PRESS_W-1:0] PRESS_MAX = '1;

  logic             btn_s;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept_rise, accept_fall;

  sync2 #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk1    (clk1),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_s)
  );

  // NOTE: every output of this block is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_LOW: begin
        if (btn_s) begin
          state_next = ST_WAIT_HI;
          cnt_next   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!btn_s)                state_next = ST_LOW;
        else if (cnt == TERMINAL)  state_next = ST_HIGH;
        else                       cnt_next   = cnt + 1'b1;
      end
      ST_HIGH: begin
        if (!btn_s) begin
          state_next = ST_WAIT_LO;
          cnt_next   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (btn_s)                 state_next = ST_HIGH;
        else if (cnt == TERMINAL)  state_next = ST_LOW;
        else                       cnt_next   = cnt + 1'b1;
      end
      default: state_next = ST_LOW;
    endcase
  end

  assign accept_rise = (state == ST_WAIT_HI) && (state_next == ST_HIGH);
  assign accept_fall = (state == ST_WAIT_LO) && (state_next == ST_LOW);

  // Level and strobes are registered from the transition itself so the
  // strobe lands in the same cycle the level first shows its new value.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      btn_level <= level_of(state_next);
      btn_rise  <= accept_rise;
      btn_fall  <= accept_fall;
    end
  end

  // Counted on the accepting edge, so the new count is visible together
  // with its btn_rise strobe.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      press_count <= '0;
    end else if (accept_rise && (press_count != PRESS_MAX)) begin
      press_count <= press_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random
// bounce patterns, all compared cycle by cycle against a run-length model.
module tb_btn_debounce;

  localparam int STABLE = 16;

  logic       clk1;
  logic       reset_n;
  logic       btn_raw;
  logic       lvl_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       lvl_b, rise_b, fall_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  btn_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(16), .PRESS_W(8)) dut_a (
    .clk1        (clk1),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (lvl_a),
    .btn_rise    (rise_a),
    .btn_fall    (fall_a),
    .press_count (cnt_a)
  );

  btn_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(16), .PRESS_W(2)) dut_b (
    .clk1        (clk1),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (lvl_b),
    .btn_rise    (rise_b),
    .btn_fall    (fall_b),
    .press_count (cnt_b)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Reference model: the raw input reaches the decision two edges late; a
  // new level is accepted once it has been seen on STABLE+1 consecutive edges
  // (the entry edge plus STABLE counted edges); any agreeing sample restarts.
  logic m_d1, m_d2, m_lvl, m_rise, m_fall;
  int   m_run, m_press;

  always @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_lvl <= 1'b0;
      m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0; m_press <= 0;
    end else begin
      m_d1   <= btn_raw;
      m_d2   <= m_d1;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (m_d2 != m_lvl) begin
        if (m_run == STABLE) begin
          m_lvl <= m_d2;
          m_run <= 0;
          if (m_d2) begin
            m_rise  <= 1'b1;
            m_press <= m_press + 1;
          end else begin
            m_fall <= 1'b1;
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  logic [10:0] obs_a, exp_a;
  logic [4:0]  obs_b, exp_b;

  always_comb begin
    obs_a = {lvl_a, rise_a, fall_a, cnt_a};
    obs_b = {lvl_b, rise_b, fall_b, cnt_b};
    exp_a = {m_lvl, m_rise, m_fall, 8'((m_press > 255) ? 255 : m_press)};
    exp_b = {m_lvl, m_rise, m_fall, 2'((m_press > 3) ? 3 : m_press)};
  end

  task automatic tick(input logic v);
    @(negedge clk1);
    btn_raw = v;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    int rises = 0;
    int lat = 0;
    reset_n = 1'b0;
    btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk1); #1;
      n_cmp++;
      if ({obs_a, obs_b} !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got a=%b b=%b want all zero", i, obs_a, obs_b);
      end
    end
    @(negedge clk1);
    reset_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk1); #1;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_bad++;
        $display("FAIL reset_release cyc=%0d got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_a, exp_b);
      end
      if (rise_a) begin
        rises++;
        if (lat == 0) lat = i;
      end
    end
    n_cmp++;
    if (rises != 1) begin
      n_bad++;
      $display("FAIL reset_release_rises got %0d want 1", rises);
    end
    n_cmp++;
    if (lat < 18 || lat > 20) begin
      n_bad++;
      $display("FAIL reset_release_latency got %0d want 18..20", lat);
    end
  endtask

  task automatic test_clean_press();
    int rises = 0, falls = 0, lat_r = 0, lat_f = 0;
    for (int i = 0; i < 25; i++) tick(1'b0);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_bad++;
        $display("FAIL clean_press cyc=%0d got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_a, exp_b);
      end
      if (rise_a) begin rises++; if (lat_r == 0) lat_r = i; end
    end
    n_cmp++;
    if (rises != 1 || lat_r < 18 || lat_r > 20 || cnt_a !== 8'd2) begin
      n_bad++;
      $display("FAIL clean_press_summary rises=%0d lat=%0d count=%0d want 1, 18..20, 2", rises, lat_r, cnt_a);
    end
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_bad++;
        $display("FAIL clean_release cyc=%0d got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_a, exp_b);
      end
      if (fall_a) begin falls++; if (lat_f == 0) lat_f = i; end
    end
    n_cmp++;
    if (falls != 1 || lat_f < 18 || lat_f > 20 || lvl_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_release_summary falls=%0d lat=%0d level=%b want 1, 18..20, 0", falls, lat_f, lvl_a);
    end
  endtask

  task automatic test_bounce();
    int runs [5] = '{3, 5, 10, 15, 40};
    logic v = 1'b1;
    int rises = 0, lat = 0, cyc = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 1; i <= runs[r]; i++) begin
        tick(v);
        cyc++;
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
          n_bad++;
          $display("FAIL bounce cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a, exp_b);
        end
        if (rise_a) begin
          rises++;
          if (r == 4 && lat == 0) lat = i;
        end
      end
      v = ~v;
    end
    n_cmp++;
    if (rises != 1 || lat < 18 || lat > 20) begin
      n_bad++;
      $display("FAIL bounce_summary rises=%0d lat=%0d want 1, 18..20", rises, lat);
    end
    for (int i = 0; i < 25; i++) tick(1'b0);
  endtask

  task automatic test_terminal_bounce();
    logic [7:0] cnt0 = cnt_a;
    int early = 0, late = 0;
    for (int i = 0; i < 16; i++) tick(1'b1);
    tick(1'b0);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_bad++;
        $display("FAIL terminal_bounce cyc=%0d got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_a, exp_b);
      end
      if (i <= 10) begin
        if (rise_a || lvl_a || cnt_a != cnt0) early++;
      end else if (rise_a) begin
        late++;
      end
    end
    n_cmp++;
    if (early != 0 || late != 1) begin
      n_bad++;
      $display("FAIL terminal_bounce_summary early_changes=%0d later_rises=%0d want 0, 1", early, late);
    end
    for (int i = 0; i < 25; i++) tick(1'b0);
  endtask

  task automatic test_saturation();
    int want_b [5] = '{1, 2, 3, 3, 3};
    @(negedge clk1);
    reset_n = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk1);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 50; i++) begin
        tick(i < 25);
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
          n_bad++;
          $display("FAIL saturation press=%0d cyc=%0d got a=%b b=%b want a=%b b=%b", k, i, obs_a, obs_b, exp_a, exp_b);
        end
      end
      n_cmp++;
      if (cnt_b !== 2'(want_b[k]) || cnt_a !== 8'(k + 1)) begin
        n_bad++;
        $display("FAIL saturation_count press=%0d got b=%0d a=%0d want b=%0d a=%0d", k, cnt_b, cnt_a, want_b[k], k + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    int steps = 0, falls = 0;
    for (int i = 0; i < 25; i++) tick(1'b1);
    while (!(m_lvl && m_run == 9) && steps < 20) begin
      tick(1'b0);
      steps++;
    end
    n_cmp++;
    if (!(m_lvl && m_run == 9)) begin
      n_bad++;
      $display("FAIL mid_reset_align got steps=%0d want release qualification at count 8", steps);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs_a, obs_b} !== 16'h0) begin
      n_bad++;
      $display("FAIL mid_reset_async got a=%b b=%b want all zero", obs_a, obs_b);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk1); #1;
      n_cmp++;
      if ({obs_a, obs_b} !== 16'h0) begin
        n_bad++;
        $display("FAIL mid_reset_hold cyc=%0d got a=%b b=%b want all zero", i, obs_a, obs_b);
      end
    end
    @(negedge clk1);
    reset_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick(1'b0);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
        n_bad++;
        $display("FAIL mid_reset_after cyc=%0d got a=%b b=%b want a=%b b=%b", i, obs_a, obs_b, exp_a, exp_b);
      end
      if (fall_a) falls++;
    end
    n_cmp++;
    if (falls != 0) begin
      n_bad++;
      $display("FAIL mid_reset_no_fall got %0d falls want 0", falls);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    logic v;
    while (cyc < 3000) begin
      int len = int'($urandom_range(1, 30));
      v = logic'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        tick(v);
        cyc++;
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
          n_bad++;
          $display("FAIL random cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, obs_a, obs_b, exp_a, exp_b);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_terminal_bounce();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
